irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_irq_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter
//
// Collects up to NSRC level interrupt sources, latches their rising edges
// into a pending register, and hands exactly one source at a time to the
// CPU through an IDLE -> ISSUE -> ACTIVE handshake. Software sees the block
// through a small register file (combinational read, one write per cycle).
//
// Register map (address a):
//   0  enable    RW  d[NSRC-1:0]
//   1  pending   R   write-1-to-clear
//   2  status    R   {bit9 interrupt, bit8 in_service, bits3:0 claimed id}
//   3  complete  W   d[3:0] = id being retired
//   4  pointer   R   round-robin pointer (reads 0 in fixed-priority build)
//   5..7         reads 0, writes ignored
//
// Ports:
//   clk        sole clock, all logic on posedge
//   rst        synchronous, active-high reset
//   irq_src    level interrupt requests (asynchronous, double-flopped here)
//   interrupt  registered request to the CPU, high only in ISSUE
//   int_reply  CPU acknowledge, sampled each posedge
//   a, d, we   register address, write data, write strobe
//   spo        combinational read data for address a
//
// Build option:
//   IRQ_ARBITER_ROUND_ROBIN_EN  defined   -> rotating priority starting at
//                                            the arbitration pointer
//                              undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module irq_arbiter #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    output logic            interrupt,
    input  logic            int_reply,
    input  logic [2:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] src_qq;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] pending;
    logic [3:0]      claimed;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clr_mask;
    logic [NSRC-1:0] grant_onehot;
    logic [NSRC-1:0] pending_next;
    logic [2:0]      winner;
    logic            grant_valid;
    logic            grant;
    logic            complete_hit;
    logic            in_service;
    logic            unused_d;

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    logic [2:0]      pointer;
    logic [2:0]      pointer_next;
`endif

    // Upper write-data bits have no destination for narrow NSRC.
    assign unused_d = ^d[31:NSRC];

    // ------------------------------------------------------------------
    // Edge detection and pending bookkeeping
    // ------------------------------------------------------------------
    assign rise       = src_q & ~src_qq;
    assign eligible   = pending & enable;
    assign clr_mask   = (we && a == 3'd1) ? d[NSRC-1:0] : '0;
    assign grant      = grant_valid && (state == IDLE);
    assign in_service = (state == ACTIVE);

    assign complete_hit = we && (a == 3'd3) && (d[3:0] == claimed)
                          && (state == ACTIVE);

    // A fresh edge is OR-ed in last so it beats both a software clear and
    // the grant clear of the same bit; an edge on the source being served
    // is therefore kept for a later grant.
    assign pending_next = (pending & ~clr_mask & ~grant_onehot) | (rise & enable);

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave a value held (latch).
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        // First eligible index at or above the pointer, wrapping at NSRC.
        for (int k = 0; k < NSRC; k++) begin
            if (!grant_valid && eligible[(int'(pointer) + k) % NSRC]) begin
                grant_valid = 1'b1;
                winner      = 3'((int'(pointer) + k) % NSRC);
            end
        end
`else
        // Scan downward so the lowest eligible index is written last.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_valid = 1'b1;
                winner      = 3'(i);
            end
        end
`endif
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            grant_onehot[i] = grant && (winner == 3'(i));
        end
    end

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    assign pointer_next = 3'((int'(winner) + 1) % NSRC);
`endif

    // ------------------------------------------------------------------
    // State, registers and registered outputs
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            src_qq    <= '0;
            enable    <= '0;
            pending   <= '0;
            claimed   <= '0;
            state     <= IDLE;
            interrupt <= 1'b0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
            pointer   <= '0;
`endif
        end else begin
            src_q   <= irq_src;
            src_qq  <= src_q;
            pending <= pending_next;

            if (we && a == 3'd0) begin
                enable <= d[NSRC-1:0];
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        claimed   <= {1'b0, winner};
                        state     <= ISSUE;
                        interrupt <= 1'b1;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
                        pointer   <= pointer_next;
`endif
                    end
                end
                // Register writes never cancel an issued request; only the
                // CPU acknowledge moves it on.
                ISSUE: begin
                    if (int_reply) begin
                        state     <= ACTIVE;
                        interrupt <= 1'b0;
                    end
                end
                // Only a completion naming the claimed id retires the grant.
                ACTIVE: begin
                    if (complete_hit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    always_comb begin
        spo = '0;
        case (a)
            3'd0: spo[NSRC-1:0] = enable;
            3'd1: spo[NSRC-1:0] = pending;
            3'd2: begin
                spo[9]   = interrupt;
                spo[8]   = in_service;
                spo[3:0] = claimed;
            end
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
            3'd4: spo[2:0] = pointer;
`endif
            default: spo = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irq_arbiter
//
// Self-checking bench for irq_arbiter (NSRC = 8). Register-map behaviour is
// driven from a vector table; grant ordering uses a queue of expected ids
// pushed when sources are pulsed and popped when the DUT raises interrupt.
// Hand-written sequences cover latency, completion-id matching, clear vs set
// precedence and reset during a grant. Round-robin expectations are selected
// with IRQ_ARBITER_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_irq_arbiter;

    localparam int NSRC = 8;

    logic            clk;
    logic            rst;
    logic [NSRC-1:0] irq_src;
    logic            interrupt;
    logic            int_reply;
    logic [2:0]      a;
    logic [31:0]     d;
    logic            we;
    logic [31:0]     spo;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    irq_arbiter #(.NSRC(NSRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .interrupt (interrupt),
        .int_reply (int_reply),
        .a         (a),
        .d         (d),
        .we        (we),
        .spo       (spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        d  = data;
        tick();
        we = 1'b0;
        d  = '0;
    endtask

    task automatic reg_read(input logic [2:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = spo;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        we        = 1'b0;
        a         = '0;
        d         = '0;
        irq_src   = '0;
        int_reply = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [NSRC-1:0] srcs);
        irq_src = srcs;
        tick();
        irq_src = '0;
    endtask

    task automatic wait_interrupt(input string tag);
        int n = 0;
        while (interrupt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_irq"}, {31'd0, interrupt}, 32'd1);
    endtask

    // Wait for a grant, compare its id against the scoreboard, acknowledge
    // it, optionally re-pulse sources while ACTIVE, then complete it.
    task automatic serve_grant(input string tag, input logic [NSRC-1:0] repulse);
        logic [31:0] v;
        logic [3:0]  exp_id;
        wait_interrupt(tag);
        reg_read(3'd2, v);
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
        check({tag, "_id"}, {28'd0, v[3:0]}, {28'd0, exp_id});
        int_reply = 1'b1;
        tick();
        int_reply = 1'b0;
        reg_read(3'd2, v);
        check({tag, "_insvc"}, {30'd0, v[9:8]}, 32'h1);
        if (repulse != '0) begin
            pulse(repulse);
            repeat (3) tick();
        end
        reg_write(3'd3, {28'd0, v[3:0]});
    endtask

    initial begin
        logic [31:0] v;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_interrupt", {31'd0, interrupt}, 32'd0);
        reg_read(3'd0, v); check("rst_enable", v, 32'd0);
        reg_read(3'd1, v); check("rst_pending", v, 32'd0);
        reg_read(3'd2, v); check("rst_status", v, 32'd0);

        // ---------------- register map table ----------------
        vecs[0] = '{1'b1, 3'd0, 32'hFFFF_FFA5, 3'd0, 32'h0000_00A5};
        vecs[1] = '{1'b0, 3'd0, 32'h0,         3'd1, 32'h0};
        vecs[2] = '{1'b0, 3'd0, 32'h0,         3'd2, 32'h0};
        vecs[3] = '{1'b1, 3'd5, 32'h1234_5678, 3'd5, 32'h0};
        vecs[4] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0};
        vecs[5] = '{1'b0, 3'd0, 32'h0,         3'd7, 32'h0};
        vecs[6] = '{1'b1, 3'd3, 32'h0,         3'd2, 32'h0};
        vecs[7] = '{1'b1, 3'd0, 32'h0000_0000, 3'd0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) reg_write(vecs[i].wa, vecs[i].wd);
            reg_read(vecs[i].ra, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end
        reg_read(3'd4, v);
        check("ptr_after_reset", v, 32'd0);

        // ---------------- basic flow and latency ----------------
        do_reset();
        reg_write(3'd0, 32'h01);
        irq_src = 8'h01;
        tick();                                  // edge 0
        irq_src = '0;
        tick();                                  // edge 1
        reg_read(3'd1, v); check("lat_pending_e1", v, 32'h01);
        check("lat_irq_e1", {31'd0, interrupt}, 32'd0);
        tick();                                  // edge 2
        check("lat_irq_e2", {31'd0, interrupt}, 32'd1);
        reg_read(3'd2, v); check("lat_status_issue", v, 32'h200);
        reg_read(3'd1, v); check("lat_pending_cleared", v, 32'h0);
        int_reply = 1'b1;
        tick();
        int_reply = 1'b0;
        reg_read(3'd2, v); check("lat_status_active", v, 32'h100);
        reg_write(3'd3, 32'h0);
        reg_read(3'd2, v); check("lat_status_idle", v, 32'h000);

        // ---------------- simultaneous sources 2 and 3 ----------------
        do_reset();
        reg_write(3'd0, 32'h0C);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        pulse(8'h0C);
        serve_grant("g23a", '0);
        serve_grant("g23b", '0);
        reg_read(3'd4, v);
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        check("ptr_after_g23", v, 32'd4);
`else
        check("ptr_after_g23", v, 32'd0);
`endif

        // ---------------- fairness between sources 0 and 1 ----------------
        do_reset();
        reg_write(3'd0, 32'h03);
        for (int i = 0; i < 4; i++) begin
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
            exp_q.push_back(4'(i % 2));
`else
            exp_q.push_back(4'd0);
`endif
        end
        pulse(8'h03);
        for (int i = 0; i < 4; i++) begin
            serve_grant($sformatf("fair%0d", i), 8'h03);
        end

        // ---------------- completion id matching, ISSUE robustness ----------
        do_reset();
        reg_write(3'd0, 32'h02);
        pulse(8'h02);
        wait_interrupt("cid");
        reg_write(3'd3, 32'h1);                  // complete in ISSUE: ignored
        check("cid_issue_cmpl", {31'd0, interrupt}, 32'd1);
        reg_write(3'd0, 32'h0);                  // enable write: no cancel
        check("cid_issue_en", {31'd0, interrupt}, 32'd1);
        reg_write(3'd0, 32'h02);
        int_reply = 1'b1;
        tick();
        int_reply = 1'b0;
        reg_write(3'd3, 32'h2);                  // wrong id
        reg_read(3'd2, v); check("cid_wrong_id", v, 32'h101);
        reg_write(3'd3, 32'h1);                  // right id
        reg_read(3'd2, v); check("cid_right_id", v, 32'h001);

        // ---------------- enable gating, set beats write-1-to-clear --------
        do_reset();
        pulse(8'h20);
        repeat (3) tick();
        reg_read(3'd1, v); check("gate_disabled", v, 32'h0);
        reg_write(3'd0, 32'h20);
        irq_src = 8'h20;
        tick();                                  // rise now visible
        irq_src = '0;
        reg_write(3'd1, 32'h20);                 // clear in the same cycle
        reg_read(3'd1, v); check("set_beats_clear", v, 32'h20);

        // ---------------- reset during ISSUE ----------------
        do_reset();
        reg_write(3'd0, 32'h03);
        pulse(8'h03);
        wait_interrupt("rstiss");
        reg_read(3'd1, v); check("rstiss_pending_pre", v, 32'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstiss_irq", {31'd0, interrupt}, 32'd0);
        reg_read(3'd1, v); check("rstiss_pending", v, 32'h0);
        reg_read(3'd0, v); check("rstiss_enable", v, 32'h0);
        reg_read(3'd2, v); check("rstiss_status", v, 32'h0);
        repeat (5) tick();
        check("rstiss_no_stale", {31'd0, interrupt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
